io_ports: RTL and testbench

//  Memory-mapped I/O stage beside data_memory on the CPU data bus. It owns the two addresses that data_memory leaves undriven:
//  IN_PORT_ADDR (RX data) and OUT_PORT_ADDR (TX data on write, status on read).
//  It bridges the CPU to an external device through two 4-phase valid/ack handshakes, each with a synchronized inbound control line.

---
 rtl/drfa_io_pkg.sv | 23 ++
 rtl/io_sync.sv | 24 ++
 rtl/io_ports.sv | 156 +++++++++++++++
 tb/tb_io_ports.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drfa_io_pkg.sv
// Shared definitions for the CPU data-bus I/O ports: the two port addresses
// (also decoded by data_memory), status bit positions and FSM encodings.
package drfa_io_pkg;

  localparam logic [9:0] IN_PORT_ADDR  = 10'h3FE;
  localparam logic [9:0] OUT_PORT_ADDR = 10'h3FF;

  localparam int ST_RX_FULL = 0;
  localparam int ST_TX_BUSY = 1;
  localparam int ST_OVF     = 2;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/io_sync.sv
// Multi-flop synchronizer for a single asynchronous control line.
module io_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  // Shift the async input through STAGES flops; reset clears the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/io_ports.sv
// Memory-mapped RX/TX byte ports on the CPU data bus, bridged to an external
// device through two 4-phase valid/ack handshakes.
module io_ports #(
  parameter int ADDR_WIDTH                   = 10,
  parameter int DATA_WIDTH                   = 8,
  parameter logic [ADDR_WIDTH-1:0] IN_PORT_ADDR  = drfa_io_pkg::IN_PORT_ADDR,
  parameter logic [ADDR_WIDTH-1:0] OUT_PORT_ADDR = drfa_io_pkg::OUT_PORT_ADDR,
  parameter int SYNC_STAGES                  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_write_en,
  input  logic                  in_read_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_ext_valid,
  input  logic [DATA_WIDTH-1:0] in_ext_data,
  output logic                  out_ext_ack,
  output logic                  out_ext_valid,
  output logic [DATA_WIDTH-1:0] out_ext_data,
  input  logic                  in_ext_ack
);

  import drfa_io_pkg::*;

  logic                  v_s;
  logic                  a_s;
  rx_state_t             rx_state, rx_next;
  tx_state_t             tx_state, tx_next;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic                  rx_full;
  logic                  ovf;
  logic                  tx_busy;
  logic                  rx_capture;
  logic                  tx_load;
  logic                  ovf_set;
  logic                  rd_in;
  logic                  rd_status;
  logic                  wr_out;
  logic [DATA_WIDTH-1:0] status;

  io_sync #(.STAGES(SYNC_STAGES)) u_sync_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_ext_valid),
    .q     (v_s)
  );

  io_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_ext_ack),
    .q     (a_s)
  );

  assign rd_in     = in_read_en  && (in_addr == IN_PORT_ADDR);
  assign rd_status = in_read_en  && (in_addr == OUT_PORT_ADDR);
  assign wr_out    = in_write_en && (in_addr == OUT_PORT_ADDR);
  assign tx_busy   = (tx_state != TX_IDLE);

  // Status byte: unused upper bits read as zero.
  always_comb begin
    status             = '0;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_BUSY] = tx_busy;
    status[ST_OVF]     = ovf;
  end

  // Bus read mux; released whenever the access is not ours so data_memory can drive.
  assign out_data = rd_in     ? rx_reg :
                    rd_status ? status :
                                {DATA_WIDTH{1'bz}};

  // RX next state: a byte is only taken while the holding register is empty.
  always_comb begin
    rx_next    = rx_state;
    rx_capture = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (v_s && !rx_full) begin
          rx_capture = 1'b1;
          rx_next    = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!v_s) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // RX state, holding register and full flag. Capture needs rx_full=0, so it
  // can never coincide with a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_reg   <= '0;
      rx_full  <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (rx_capture) begin
        rx_reg  <= in_ext_data;
        rx_full <= 1'b1;
      end else if (rd_in) begin
        rx_full <= 1'b0;
      end
    end
  end

  // The ack is the RX state flop itself, so the producer sees a glitch-free line.
  assign out_ext_ack = (rx_state == RX_ACK);

  // TX next state; a CPU write outside TX_IDLE is dropped and flagged.
  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    ovf_set = wr_out && (tx_state != TX_IDLE);
    case (tx_state)
      TX_IDLE: begin
        if (wr_out) begin
          tx_load = 1'b1;
          tx_next = TX_SEND;
        end
      end
      TX_SEND: begin
        if (a_s) tx_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (!a_s) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX state, registered valid/data to the consumer, and sticky overflow
  // (a same-edge set beats the status-read clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state      <= TX_IDLE;
      out_ext_valid <= 1'b0;
      out_ext_data  <= '0;
      ovf           <= 1'b0;
    end else begin
      tx_state      <= tx_next;
      out_ext_valid <= (tx_next == TX_SEND);
      if (tx_load) out_ext_data <= in_data;
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (rd_status) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_ports.sv
// Testbench for io_ports: directed scenarios followed by random bus and
// handshake traffic compared against a flag-level model of the port.
module tb_io_ports;

  localparam logic [9:0] A_IN  = 10'h3FE;
  localparam logic [9:0] A_OUT = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_addr;
  logic       in_write_en;
  logic       in_read_en;
  logic [7:0] in_data;
  wire  [7:0] out_data;
  logic       in_ext_valid;
  logic [7:0] in_ext_data;
  wire        out_ext_ack;
  wire        out_ext_valid;
  wire  [7:0] out_ext_data;
  logic       in_ext_ack;

  int checks = 0;
  int errors = 0;

  // Reference model: the architectural flags and registers
  logic       m_rx_full, m_ovf, m_tx_busy;
  logic [7:0] m_rx_reg, m_tx_data;

  io_ports dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_addr       (in_addr),
    .in_write_en   (in_write_en),
    .in_read_en    (in_read_en),
    .in_data       (in_data),
    .out_data      (out_data),
    .in_ext_valid  (in_ext_valid),
    .in_ext_data   (in_ext_data),
    .out_ext_ack   (out_ext_ack),
    .out_ext_valid (out_ext_valid),
    .out_ext_data  (out_ext_data),
    .in_ext_ack    (in_ext_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_status();
    return {5'b0, m_ovf, m_tx_busy, m_rx_full};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A released bus reads as z on 4-state simulators and 0 on 2-state ones.
  task automatic check_z(input string tag, input logic [7:0] obs);
    logic ok;
    ok = (obs === 8'bzzzzzzzz) || (obs === 8'h00);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed=%h expected=zz", tag, obs);
    end
  endtask

  task automatic bus_read(input logic [9:0] addr, output logic [7:0] data);
    @(negedge clk);
    in_addr    = addr;
    in_read_en = 1'b1;
    #1 data = out_data;
    @(posedge clk);
    #1;
    in_read_en = 1'b0;
    in_addr    = '0;
  endtask

  task automatic bus_write(input logic [9:0] addr, input logic [7:0] data);
    @(negedge clk);
    in_addr     = addr;
    in_data     = data;
    in_write_en = 1'b1;
    @(posedge clk);
    #1;
    in_write_en = 1'b0;
    in_addr     = '0;
  endtask

  // Full producer handshake for one byte, with the valid-to-ack latency checked.
  task automatic rx_send(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_ext_data  = b;
    in_ext_valid = 1'b1;
    n = 0;
    while (out_ext_ack !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("rx_ack_latency", 8'(n), 8'd3);
    @(negedge clk);
    in_ext_valid = 1'b0;
    n = 0;
    while (out_ext_ack !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ack_release", 8'(n < 20), 8'd1);
    m_rx_full = 1'b1;
    m_rx_reg  = b;
  endtask

  // Consumer side: accept the pending byte and close the 4-phase handshake.
  task automatic tx_consume();
    int n;
    if (m_tx_busy) begin
      @(negedge clk);
      check("tx_data", out_ext_data, m_tx_data);
      check("tx_valid_hi", {7'b0, out_ext_valid}, 8'd1);
      in_ext_ack = 1'b1;
      n = 0;
      while (out_ext_valid !== 1'b0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("tx_valid_drop", 8'(n < 20), 8'd1);
      in_ext_ack = 1'b0;
      repeat (4) @(posedge clk);
      m_tx_busy = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_rx_full = 1'b0;
    m_ovf     = 1'b0;
    m_tx_busy = 1'b0;
    m_rx_reg  = 8'h00;
    m_tx_data = 8'h00;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    int n;
    rst_n        = 1'b0;
    in_addr      = '0;
    in_write_en  = 1'b0;
    in_read_en   = 1'b0;
    in_data      = '0;
    in_ext_valid = 1'b0;
    in_ext_data  = '0;
    in_ext_ack   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a TX transfer
    bus_write(A_OUT, 8'h77);
    check("pre_rst_valid", {7'b0, out_ext_valid}, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_valid", {7'b0, out_ext_valid}, 8'd0);
    check("rst_ack", {7'b0, out_ext_ack}, 8'd0);
    check("rst_txdata", out_ext_data, 8'h00);
    check_z("rst_bus_idle", out_data);
    in_addr    = A_OUT;
    in_read_en = 1'b1;
    #1 check("rst_status", out_data, 8'h00);
    in_read_en = 1'b0;
    in_addr    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // RX capture, then backpressure on a second byte
    rx_send(8'hA5);
    bus_read(A_OUT, d);
    check("rx_status_full", d, 8'h01);
    @(negedge clk);
    in_ext_data  = 8'h3C;
    in_ext_valid = 1'b1;
    repeat (8) @(negedge clk);
    check("rx_stall_ack", {7'b0, out_ext_ack}, 8'd0);
    bus_read(A_IN, d);
    check("rx_pop_a5", d, 8'hA5);
    n = 0;
    while (out_ext_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ack_after_pop", 8'(n < 20), 8'd1);
    @(negedge clk);
    in_ext_valid = 1'b0;
    n = 0;
    while (out_ext_ack !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ack_release2", 8'(n < 20), 8'd1);
    bus_read(A_OUT, d);
    check("rx_status_full2", d, 8'h01);
    bus_read(A_IN, d);
    check("rx_pop_3c", d, 8'h3C);
    bus_read(A_OUT, d);
    check("rx_status_empty", d, 8'h00);
    m_rx_full = 1'b0;
    m_rx_reg  = 8'h3C;

    // TX send and overflow
    bus_write(A_OUT, 8'h5A);
    check("tx_valid", {7'b0, out_ext_valid}, 8'd1);
    check("tx_data_5a", out_ext_data, 8'h5A);
    bus_read(A_OUT, d);
    check("tx_status_busy", d, 8'h02);
    bus_write(A_OUT, 8'hFF);
    check("ovf_data_kept", out_ext_data, 8'h5A);
    bus_read(A_OUT, d);
    check("ovf_status", d, 8'h06);
    bus_read(A_OUT, d);
    check("ovf_cleared", d, 8'h02);
    m_tx_busy = 1'b1;
    m_tx_data = 8'h5A;
    tx_consume();
    bus_read(A_OUT, d);
    check("tx_status_done", d, 8'h00);

    // Bus isolation
    bus_read(10'h000, d);
    check_z("iso_000", d);
    bus_read(10'h3FD, d);
    check_z("iso_3fd", d);
    bus_write(A_IN, 8'h99);
    bus_write(10'h010, 8'h42);
    check("iso_no_tx", {7'b0, out_ext_valid}, 8'd0);
    bus_read(A_OUT, d);
    check("iso_status", d, 8'h00);
    bus_read(A_IN, d);
    check("iso_stale_rx", d, 8'h3C);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 4))
        0: if (!m_rx_full) rx_send(b);
        1: begin
          bus_read(A_IN, d);
          check("rnd_rx", d, m_rx_reg);
          m_rx_full = 1'b0;
        end
        2: begin
          bus_read(A_OUT, d);
          check("rnd_status", d, m_status());
          m_ovf = 1'b0;
        end
        3: begin
          bus_write(A_OUT, b);
          if (m_tx_busy) begin
            m_ovf = 1'b1;
          end else begin
            m_tx_busy = 1'b1;
            m_tx_data = b;
          end
          check("rnd_tx_data", out_ext_data, m_tx_data);
          check("rnd_tx_valid", {7'b0, out_ext_valid}, {7'b0, m_tx_busy});
        end
        default: tx_consume();
      endcase
    end
    bus_read(A_OUT, d);
    check("final_status", d, m_status());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
